// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter states, frame geometry and keyboard command bytes.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    BITS      = 3'd3,
    STOP      = 3'd4,
    ACK       = 3'd5,
    WAIT_IDLE = 3'd6
  } state_t;

  // Start + 8 data + parity + stop; the host shifts data and parity only.
  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_SHIFT_BITS = PS2_FRAME_BITS - 2;
  localparam int unsigned PS2_IDX_W      = 4;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } frame_t;

  // Odd parity: the parity bit makes the count of ones across data+parity odd.
  function automatic frame_t frame_payload(input logic [7:0] data);
    frame_t f;
    f.parity = ~^data;
    f.data   = data;
    return f;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge detector.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Reset to the idle-high line level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= line;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall_c = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, device-clocked shift-out,
// acknowledge check and timeout, with busy flagging the frame for the receiver.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned CNT_WIDTH      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txData,
  input  logic       txSend,
  input  logic       ps2CLK,
  input  logic       ps2DATA,
  output logic       ps2CLKLow,
  output logic       ps2DATALow,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [CNT_WIDTH-1:0] INH_LAST = CNT_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [PS2_IDX_W-1:0] IDX_LAST = PS2_IDX_W'(PS2_SHIFT_BITS - 1);

  state_t                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [PS2_IDX_W-1:0]        idx_q, idx_d;
  logic [PS2_SHIFT_BITS-1:0]   shift_q, shift_d;
  logic                        clk_low_d, data_low_d, busy_d, done_d, error_d;

  logic clk_s, clk_fall_c;
  logic data_s, data_fall_unused;
  logic tmo_armed_c;

  ps2_edge_sync u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line   (ps2CLK),
    .level  (clk_s),
    .fall_c (clk_fall_c)
  );

  ps2_edge_sync u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .line   (ps2DATA),
    .level  (data_s),
    .fall_c (data_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      ps2CLKLow  <= 1'b0;
      ps2DATALow <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      ps2CLKLow  <= clk_low_d;
      ps2DATALow <= data_low_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    clk_low_d   = ps2CLKLow;
    data_low_d  = ps2DATALow;
    busy_d      = busy;
    done_d      = 1'b0;
    error_d     = 1'b0;
    tmo_armed_c = 1'b0;

    case (state_q)
      IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        busy_d     = 1'b0;
        if (txSend) begin
          state_d   = INHIBIT;
          shift_d   = frame_payload(txData);
          cnt_d     = '0;
          idx_d     = '0;
          clk_low_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d    = REQ;
          data_low_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      // Start bit is already on the line; handing the clock to the device.
      REQ: begin
        clk_low_d = 1'b0;
        cnt_d     = '0;
        idx_d     = '0;
        state_d   = BITS;
      end

      BITS: begin
        tmo_armed_c = 1'b1;
        if (clk_fall_c) begin
          data_low_d = ~shift_q[0];
          shift_d    = {1'b0, shift_q[PS2_SHIFT_BITS-1:1]};
          idx_d      = idx_q + PS2_IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        tmo_armed_c = 1'b1;
        if (clk_fall_c) begin
          data_low_d = 1'b0;
          state_d    = ACK;
        end
      end

      ACK: begin
        tmo_armed_c = 1'b1;
        if (clk_fall_c) begin
          if (!data_s) begin
            state_d = WAIT_IDLE;
          end else begin
            state_d = IDLE;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      WAIT_IDLE: begin
        tmo_armed_c = 1'b1;
        if (clk_s && data_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase

    // Inter-edge watchdog shared by every device-clocked state.
    if (tmo_armed_c) begin
      if (clk_fall_c) begin
        cnt_d = '0;
      end else if (cnt_q == TMO_LAST) begin
        if (!done_d && !error_d) begin
          state_d    = IDLE;
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          busy_d     = 1'b0;
          error_d    = 1'b1;
        end
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model plus a PS/2 device model
// that clocks the frame and checks each sampled bit against a scoreboard.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INH  = 5000;
  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 30;

  localparam int MODE_ACK    = 0;
  localparam int MODE_NACK   = 1;
  localparam int MODE_SILENT = 2;
  localparam int MODE_RST4   = 3;

  localparam int OUT_NONE  = 0;
  localparam int OUT_DONE  = 1;
  localparam int OUT_ERROR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] txData;
  logic       txSend;
  logic       ps2CLK, ps2DATA;
  logic       ps2CLKLow, ps2DATALow;
  logic       busy, done, error;
  logic       dev_clk_low, dev_data_low;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned done_cnt = 0;
  int unsigned error_cnt = 0;

  logic exp_bits[$];
  int   exp_out[$];

  assign ps2CLK  = ~(ps2CLKLow | dev_clk_low);
  assign ps2DATA = ~(ps2DATALow | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_WIDTH      (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .txData     (txData),
    .txSend     (txSend),
    .ps2CLK     (ps2CLK),
    .ps2DATA    (ps2DATA),
    .ps2CLKLow  (ps2CLKLow),
    .ps2DATALow (ps2DATALow),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pulse monitor: busy must already be low and done/error exclusive.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) error_cnt++;
    if ((done || error) && !rst) begin
      check("pulse_exclusive", 32'(done & error), 32'd0);
      check("busy_at_pulse", 32'(busy), 32'd0);
    end
  end

  task automatic send(input logic [7:0] d, input int outcome);
    @(negedge clk);
    txData = d;
    txSend = 1'b1;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(~^d);
    exp_bits.push_back(1'b1);
    exp_out.push_back(outcome);
    @(negedge clk);
    txSend = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic check_bit(input string tag);
    check({tag, "_sb_avail"}, 32'(exp_bits.size() > 0), 32'd1);
    if (exp_bits.size() > 0) check(tag, 32'(ps2DATA), 32'(exp_bits.pop_front()));
  endtask

  // Device model: observes the request, then clocks the frame out of the host.
  task automatic device(input int mode, input bit check_inh);
    int  inh = 0;
    int  req = 0;
    int  n   = 0;
    int  m   = 0;
    bit  rel = 1'b0;
    while (n < 20000) begin
      if (ps2CLKLow && !ps2DATALow) inh++;
      else if (ps2CLKLow && ps2DATALow) req++;
      else if (!ps2CLKLow && ps2DATALow) begin
        rel = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    check("request_seen", 32'(rel), 32'd1);
    if (!rel) return;
    if (check_inh) begin
      check("inhibit_cycles", 32'(inh), 32'(INH));
      check("req_cycles", 32'(req), 32'd1);
    end

    if (mode == MODE_SILENT) begin
      while (!error && m < 1000) begin
        @(negedge clk);
        m++;
      end
      check("timeout_latency", 32'(m), 32'(TMO));
      return;
    end

    check_bit("start_bit");
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (mode == MODE_RST4 && i == 4) begin
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_clk_low", 32'(ps2CLKLow), 32'd0);
        check("rst_data_low", 32'(ps2DATALow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'(done | error), 32'd0);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      check_bit($sformatf("frame_bit%0d", i));
      repeat (HALF) @(negedge clk);
    end
    if (mode == MODE_ACK) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int unsigned d0, input int unsigned e0);
    int o;
    repeat (20) @(negedge clk);
    check({tag, "_out_avail"}, 32'(exp_out.size() > 0), 32'd1);
    o = (exp_out.size() > 0) ? exp_out.pop_front() : OUT_NONE;
    check({tag, "_done"}, 32'(done_cnt - d0), 32'(o == OUT_DONE));
    check({tag, "_error"}, 32'(error_cnt - e0), 32'(o == OUT_ERROR));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_clk_low"}, 32'(ps2CLKLow), 32'd0);
    check({tag, "_data_low"}, 32'(ps2DATALow), 32'd0);
    check({tag, "_bits_left"}, 32'(exp_bits.size()), 32'd0);
  endtask

  initial begin
    int unsigned d0, e0;
    rst = 1'b1;
    txSend = 1'b0;
    txData = PS2_ACK;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_clk_low", 32'(ps2CLKLow), 32'd0);
    check("reset_data_low", 32'(ps2DATALow), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Set-LEDs command, acknowledged.
    d0 = done_cnt; e0 = error_cnt;
    send(PS2_CMD_SET_LEDS, OUT_DONE);
    device(MODE_ACK, 1'b1);
    finish_frame("t1", d0, e0);

    // All-zero byte: parity must be 1.
    d0 = done_cnt; e0 = error_cnt;
    send(8'h00, OUT_DONE);
    device(MODE_ACK, 1'b1);
    finish_frame("t2", d0, e0);

    // Device refuses the frame.
    d0 = done_cnt; e0 = error_cnt;
    send(8'hA5, OUT_ERROR);
    device(MODE_NACK, 1'b0);
    finish_frame("t3", d0, e0);

    // Device never clocks after release.
    d0 = done_cnt; e0 = error_cnt;
    send(8'h3C, OUT_ERROR);
    device(MODE_SILENT, 1'b0);
    exp_bits.delete();
    finish_frame("t4", d0, e0);

    // Second request during INHIBIT must be dropped.
    d0 = done_cnt; e0 = error_cnt;
    send(PS2_CMD_ENABLE, OUT_DONE);
    fork
      device(MODE_ACK, 1'b1);
      begin
        repeat (100) @(negedge clk);
        txData = 8'h55;
        txSend = 1'b1;
        @(negedge clk);
        txSend = 1'b0;
      end
    join
    finish_frame("t5", d0, e0);

    // Reset in the middle of the data bits, then a clean frame.
    d0 = done_cnt; e0 = error_cnt;
    send(8'h81, OUT_NONE);
    device(MODE_RST4, 1'b0);
    exp_bits.delete();
    finish_frame("t6_rst", d0, e0);

    d0 = done_cnt; e0 = error_cnt;
    send(PS2_CMD_RESET, OUT_DONE);
    device(MODE_ACK, 1'b1);
    finish_frame("t6_after", d0, e0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
